// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the FSM state encoding and the iteration-counter width helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

    // Counter must be able to hold 0..W, so it needs clog2(W+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand and result interfaces of the multiplier.
// The driver side presents operands and watches busy.
// The receiver side consumes the product and its one-cycle valid pulse.
interface multiplier_input_if #(
    parameter int W = 32
);
    logic         inputs_valid;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;

    modport sync_drv (output inputs_valid, in1, in2, input busy);
    modport sync_rcv (input inputs_valid, in1, in2, output busy);
endinterface

interface multiplier_output_if #(
    parameter int W = 64
);
    logic [W-1:0] out;
    logic         output_valid;

    modport sync_drv (output out, output_valid);
    modport sync_rcv (input out, output_valid);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier: one partial product per clock.
// Accepts an operand pair in IDLE or DONE, iterates in CALC, then pulses
// output_valid for one cycle in DONE while out holds the product.
// Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining
// multiplier bits are all zero instead of always running W iterations.
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int OUTPUT_DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    multiplier_input_if.sync_rcv  in_if,
    multiplier_output_if.sync_drv out_if
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    if (OUTPUT_DATA_WIDTH != 2 * INPUT_DATA_WIDTH) begin : g_width_check
        $error("OUTPUT_DATA_WIDTH must equal 2*INPUT_DATA_WIDTH");
    end

    mul_state_t    state_reg,  state_next;
    logic [OW-1:0] acc_reg,    acc_next;
    logic [OW-1:0] mcand_reg,  mcand_next;
    logic [W-1:0]  mplier_reg, mplier_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic [OW-1:0] out_reg,    out_next;

    logic [OW-1:0] acc_sum;
    logic [W-1:0]  mplier_shift;
    logic          last_iter;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            out_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            out_reg    <= out_next;
        end
    end

    // Next-state and datapath: load operands, accumulate one bit per cycle.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        cnt_next     = cnt_reg;
        out_next     = out_reg;
        acc_sum      = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mplier_shift = mplier_reg >> 1;
`ifdef EARLY_TERM_EN
        // Nothing left to add once the unconsumed multiplier bits are zero.
        last_iter    = (cnt_reg == CNT_LAST) || (mplier_shift == '0);
`else
        last_iter    = (cnt_reg == CNT_LAST);
`endif

        case (state_reg)
            IDLE, DONE: begin
                if (in_if.inputs_valid) begin
                    acc_next    = '0;
                    mcand_next  = {{(OW - W){1'b0}}, in_if.in1};
                    mplier_next = in_if.in2;
                    cnt_next    = '0;
                    state_next  = CALC;
                end else begin
                    state_next  = IDLE;
                end
            end
            CALC: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_shift;
                cnt_next    = cnt_reg + 1'b1;
                if (last_iter) begin
                    out_next   = acc_sum;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_if.busy          = (state_reg == CALC);
    assign out_if.output_valid = (state_reg == DONE);
    assign out_if.out          = out_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: the driver pushes the
// expected product and latency for every accepted pair, a monitor pops and
// compares on each output_valid pulse and checks that out holds otherwise.
module tb_seq_shift_add_multiplier;

    localparam int W  = 32;
    localparam int OW = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multiplier_input_if  #(.W(W))  in_if ();
    multiplier_output_if #(.W(OW)) out_if ();

    seq_shift_add_multiplier #(
        .INPUT_DATA_WIDTH (W),
        .OUTPUT_DATA_WIDTH(OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in_if (in_if),
        .out_if(out_if)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] prod;
        int            t;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic [OW-1:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles spent in CALC for a given multiplier operand.
    function automatic int model_lat(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
        int m = 1;
        for (int i = 0; i < W; i++)
            if (b[i]) m = i + 1;
        return m;
`else
        return W;
`endif
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset values, result pulses against the scoreboard, out hold.
    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            check("reset_out", out_if.out, '0);
            check("reset_valid", OW'(out_if.output_valid), '0);
            check("reset_busy", OW'(in_if.busy), '0);
            sb.delete();
            last_out = '0;
        end else if (out_if.output_valid) begin
            check("valid_not_busy", OW'(in_if.busy), '0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: out=0x%0h, required no pulse (cycle %0d)", out_if.out, cyc);
            end else begin
                e = sb.pop_front();
                check("product", out_if.out, e.prod);
                check("latency", OW'(cyc - e.t), OW'(e.lat));
                last_out = e.prod;
                $display("[TB] %0d * %0d -> 0x%0h after %0d cycles", e.a, e.b, out_if.out, cyc - e.t);
            end
        end else begin
            check("out_hold", out_if.out, last_out);
        end
    end

    // Present one operand pair once the core is free; returns at the next negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        int n = 0;
        while (in_if.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: busy=%b, required 0", in_if.busy);
        end
        in_if.inputs_valid = 1'b1;
        in_if.in1 = a;
        in_if.in2 = b;
        x.a    = a;
        x.b    = b;
        x.prod = OW'(a) * OW'(b);
        x.t    = cyc + 1;
        x.lat  = model_lat(b);
        sb.push_back(x);
        @(negedge clk);
        in_if.inputs_valid = 1'b0;
    endtask

    // Operands offered while busy; the core must drop them.
    task automatic noise(input logic [W-1:0] a, input logic [W-1:0] b);
        if (in_if.busy === 1'b1) begin
            in_if.inputs_valid = 1'b1;
            in_if.in1 = a;
            in_if.in2 = b;
            @(negedge clk);
            in_if.inputs_valid = 1'b0;
        end
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (out_if.output_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL pulse_timeout: output_valid=%b, required 1", out_if.output_valid);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        in_if.inputs_valid = 1'b0;
        in_if.in1 = '0;
        in_if.in2 = '0;

        // Reset held with operands offered: outputs stay zero.
        repeat (2) @(negedge clk);
        in_if.inputs_valid = 1'b1;
        in_if.in1 = 32'd3;
        in_if.in2 = 32'd5;
        repeat (5) @(negedge clk);
        in_if.inputs_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        // Basic product and hold afterwards.
        issue(32'd3, 32'd5);
        wait_pulse();
        repeat (12) @(negedge clk);

        // Largest operands.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_pulse();
        @(negedge clk);

        // Ignored operands while busy, then back-to-back from DONE.
        issue(32'd7, 32'd9);
        repeat (3) @(negedge clk);
        noise(32'd2, 32'd2);
        wait_pulse();
        issue(32'd4, 32'd6);
        wait_pulse();
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation.
        issue(32'd100, 32'd100);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_out", out_if.out, '0);
        check("async_reset_busy", OW'(in_if.busy), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        issue(32'd2, 32'd3);
        wait_pulse();
        @(negedge clk);

        // Short-multiplier cases (early exit when enabled).
        issue(32'd7, 32'd2);
        issue(32'd5, 32'd0);
        issue(32'd1, 32'h8000_0000);
        wait_pulse();
        @(negedge clk);

        // Randomized operands, gaps and ignored requests.
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = '0;
                default: rb = 32'hFFFF_FFFF;
            endcase
            issue(ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                noise($urandom, $urandom);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Drain outstanding results.
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
